// File: rtl/tpu_pkg.sv
// Shared constants for the 2x2 TPU sequencer: opcodes, FSM states, widths.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tpu_pkg;

  localparam int N      = 2;   // systolic array dimension
  localparam int MEM_AW = 6;   // unified-memory address width
  localparam int DATA_W = 16;  // activation / weight element width
  localparam int WORD_W = 32;  // memory word width

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
  localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
  localparam logic [2:0] OP_COMPUTE     = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WL_RD,
    S_WL_LOAD,
    S_IN_RD,
    S_FEED,
    S_DRAIN,
    S_WB,
    S_CLR
  } state_t;

  // True for opcodes that do something; every other encoding behaves as NOP.
  function automatic logic is_cmd(input logic [2:0] op);
    return (op == OP_LOAD_ADDR) || (op == OP_LOAD_WEIGHT) || (op == OP_COMPUTE);
  endfunction

endpackage

// File: rtl/tpu_input_skew.sv
// Diagonal skew of two captured activation rows onto the array row inputs.
// Latency: combinational; the caller registers the result.
// Backpressure: none; step counter selects the wavefront (0..2, 3 = idle).
// Ports: i_row0/i_row1 = {A_r1, A_r0} words, i_step = feed step,
//        o_a1/o_a2 = activations for array rows 0 and 1.
module tpu_input_skew
  import tpu_pkg::*;
(
  input  logic [WORD_W-1:0] i_row0,
  input  logic [WORD_W-1:0] i_row1,
  input  logic [1:0]        i_step,
  output logic [DATA_W-1:0] o_a1,
  output logic [DATA_W-1:0] o_a2
);

  // Row 1 lags row 0 by one step, so the wavefront is (A00,0),(A01,A10),(0,A11).
  always_comb begin
    o_a1 = '0;
    o_a2 = '0;
    case (i_step)
      2'd0: o_a1 = i_row0[DATA_W-1:0];
      2'd1: begin
        o_a1 = i_row0[WORD_W-1:DATA_W];
        o_a2 = i_row1[DATA_W-1:0];
      end
      2'd2: o_a2 = i_row1[WORD_W-1:DATA_W];
      default: ;
    endcase
  end

endmodule

// File: rtl/tpu_sequencer.sv
// Instruction sequencer for a 2x2 systolic array: weight load, skewed feed, write-back.
// Latency: LOAD_ADDR 1 cycle, LOAD_WEIGHT 4 busy cycles, COMPUTE 11 busy cycles.
// Backpressure: instructions arriving while busy are dropped and flagged by instr_dropped.
// Ports: clk/reset (sync, active-low), instruction in, memory rd/wr port,
//        weight_load + w_row0/1, a_valid + a_in1/2, acc_out1/2 in, acc_clear, busy.
module tpu_sequencer #(
  parameter int N      = tpu_pkg::N,
  parameter int MEM_AW = tpu_pkg::MEM_AW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 instruction,
  output logic                        busy,
  output logic                        instr_dropped,
  output logic                        mem_rd_en,
  output logic [MEM_AW-1:0]           mem_rd_addr,
  input  logic [tpu_pkg::WORD_W-1:0]  mem_rd_data,
  output logic                        mem_wr_en,
  output logic [MEM_AW-1:0]           mem_wr_addr,
  output logic [tpu_pkg::WORD_W-1:0]  mem_wr_data,
  output logic                        weight_load,
  output logic [tpu_pkg::WORD_W-1:0]  w_row0,
  output logic [tpu_pkg::WORD_W-1:0]  w_row1,
  output logic                        a_valid,
  output logic [tpu_pkg::DATA_W-1:0]  a_in1,
  output logic [tpu_pkg::DATA_W-1:0]  a_in2,
  input  logic [tpu_pkg::WORD_W-1:0]  acc_out1,
  input  logic [tpu_pkg::WORD_W-1:0]  acc_out2,
  output logic                        acc_clear
);
  import tpu_pkg::*;

  // Feed lasts 2N-1 cycles; the counter holds the last step index.
  localparam logic [1:0] FEED_LAST = 2'(2 * N - 2);

  state_t              r_state, w_next_state;
  logic [1:0]          r_cnt, w_next_cnt, w_last_cnt;
  logic [MEM_AW-1:0]   r_base;
  logic [WORD_W-1:0]   r_row0, r_row1;
  logic [2:0]          w_opcode;
  logic                w_unused_imm;
  logic                w_rd_en, w_wr_en, w_feed, w_wload;
  logic [MEM_AW-1:0]   w_rd_ofs, w_wr_ofs;
  logic [DATA_W-1:0]   w_skew_a1, w_skew_a2;

  logic                r_busy, r_dropped, r_rd_en, r_wr_en, r_wload, r_a_valid, r_acc_clear;
  logic [MEM_AW-1:0]   r_rd_addr, r_wr_addr;
  logic [WORD_W-1:0]   r_wr_data, r_w_row0, r_w_row1;
  logic [DATA_W-1:0]   r_a_in1, r_a_in2;

  assign w_opcode     = instruction[15:13];
  assign w_unused_imm = ^instruction[12:MEM_AW];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state: each busy state runs for w_last_cnt+1 cycles.
  always_comb begin
    case (r_state)
      S_WL_RD, S_IN_RD: w_last_cnt = 2'd2;  // 2 issue cycles + 1 read latency
      S_FEED:           w_last_cnt = FEED_LAST;
      S_DRAIN, S_WB:    w_last_cnt = 2'd1;
      default:          w_last_cnt = 2'd0;
    endcase
    w_next_state = r_state;
    w_next_cnt   = r_cnt + 2'd1;
    if (r_state == S_IDLE) begin
      w_next_cnt = '0;
      if (w_opcode == OP_LOAD_WEIGHT)  w_next_state = S_WL_RD;
      else if (w_opcode == OP_COMPUTE) w_next_state = S_IN_RD;
    end else if (r_cnt == w_last_cnt) begin
      w_next_cnt = '0;
      case (r_state)
        S_WL_RD: w_next_state = S_WL_LOAD;
        S_IN_RD: w_next_state = S_FEED;
        S_FEED:  w_next_state = S_DRAIN;
        S_DRAIN: w_next_state = S_WB;
        S_WB:    w_next_state = S_CLR;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  tpu_input_skew u_skew (
    .i_row0 (r_row0),
    .i_row1 (r_row1),
    .i_step (w_next_cnt),
    .o_a1   (w_skew_a1),
    .o_a2   (w_skew_a2)
  );

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    w_rd_en     = ((w_next_state == S_WL_RD) || (w_next_state == S_IN_RD)) && (w_next_cnt != 2'd2);
    w_wr_en     = (w_next_state == S_WB);
    w_feed      = (w_next_state == S_FEED);
    w_wload     = (w_next_state == S_WL_LOAD);
    w_rd_ofs    = '0;
    w_rd_ofs[0] = w_next_cnt[0];
    w_rd_ofs[1] = (w_next_state == S_IN_RD);  // activations live at base+2/+3
    w_wr_ofs    = '0;
    w_wr_ofs[2] = 1'b1;                       // results go to base+4/+5
    w_wr_ofs[0] = w_next_cnt[0];
  end

  // Base address and captured rows (shared by weight load and compute).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base <= '0;
      r_row0 <= '0;
      r_row1 <= '0;
    end else begin
      if (r_state == S_IDLE && w_opcode == OP_LOAD_ADDR) r_base <= instruction[MEM_AW-1:0];
      if (r_state == S_WL_RD || r_state == S_IN_RD) begin
        if (r_cnt == 2'd1) r_row0 <= mem_rd_data;
        if (r_cnt == 2'd2) r_row1 <= mem_rd_data;
      end
    end
  end

  // Output registers; data/address outputs are zero when their strobe is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_dropped   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wload     <= 1'b0;
      r_w_row0    <= '0;
      r_w_row1    <= '0;
      r_a_valid   <= 1'b0;
      r_a_in1     <= '0;
      r_a_in2     <= '0;
      r_acc_clear <= 1'b0;
    end else begin
      r_busy      <= (w_next_state != S_IDLE);
      r_dropped   <= (r_state != S_IDLE) && is_cmd(w_opcode);
      r_rd_en     <= w_rd_en;
      r_rd_addr   <= w_rd_en ? r_base + w_rd_ofs : '0;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_en ? r_base + w_wr_ofs : '0;
      r_wr_data   <= !w_wr_en ? '0 : (w_next_cnt[0] ? acc_out2 : acc_out1);
      r_wload     <= w_wload;
      r_w_row0    <= w_wload ? r_row0 : '0;
      // Row 1 word is arriving on the read bus in the last WL_RD cycle.
      r_w_row1    <= w_wload ? mem_rd_data : '0;
      r_a_valid   <= w_feed;
      r_a_in1     <= w_feed ? w_skew_a1 : '0;
      r_a_in2     <= w_feed ? w_skew_a2 : '0;
      r_acc_clear <= (w_next_state == S_CLR);
    end
  end

  assign busy          = r_busy;
  assign instr_dropped = r_dropped;
  assign mem_rd_en     = r_rd_en;
  assign mem_rd_addr   = r_rd_addr;
  assign mem_wr_en     = r_wr_en;
  assign mem_wr_addr   = r_wr_addr;
  assign mem_wr_data   = r_wr_data;
  assign weight_load   = r_wload;
  assign w_row0        = r_w_row0;
  assign w_row1        = r_w_row1;
  assign a_valid       = r_a_valid;
  assign a_in1         = r_a_in1;
  assign a_in2         = r_a_in2;
  assign acc_clear     = r_acc_clear;

endmodule
